bmu_scan_ctrl: RTL



---
 rtl/som_pkg.sv | 16 +
 rtl/bmu_best_reg.sv | 44 ++++
 rtl/bmu_scan_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/som_pkg.sv
// Shared widths, constants and scan-state encoding for the SOM BMU search blocks.
package som_pkg;

    localparam int unsigned DIST_W  = 11;
    localparam int unsigned WGT_W   = 24;
    localparam int unsigned COORD_W = 3;

    localparam logic [DIST_W-1:0] DIST_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/bmu_best_reg.sv
// Compare-and-hold register for the running best candidate; loads only on a strictly
// smaller distance so ties keep the earlier row.
module bmu_best_reg
    import som_pkg::*;
#(
    parameter int unsigned ROW_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clr,
    input  logic                i_vld,
    input  logic [DIST_W-1:0]   i_dist,
    input  logic [COORD_W-1:0]  i_x,
    input  logic [COORD_W-1:0]  i_y,
    input  logic [ROW_W-1:0]    i_row,
    input  logic [WGT_W-1:0]    i_w,
    output logic [DIST_W-1:0]   o_dist,
    output logic [COORD_W-1:0]  o_x,
    output logic [COORD_W-1:0]  o_y,
    output logic [ROW_W-1:0]    o_row,
    output logic [WGT_W-1:0]    o_w
);

    logic w_load;

    assign w_load = i_vld && (i_dist < o_dist);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            o_dist <= DIST_MAX;
            o_x    <= '0;
            o_y    <= '0;
            o_row  <= '0;
            o_w    <= '0;
        end else if (w_load) begin
            o_dist <= i_dist;
            o_x    <= i_x;
            o_y    <= i_y;
            o_row  <= i_row;
            o_w    <= i_w;
        end
    end

endmodule

// File: rtl/bmu_scan_ctrl.sv
// BMU search sequencer: walks map rows one fetch at a time and keeps the global minimum.
// Optional threshold compare / no_match flag enabled by defining BMU_SCAN_THRESH_EN.
module bmu_scan_ctrl
    import som_pkg::*;
#(
    parameter int unsigned NUM_ROWS = 8,
    parameter int unsigned ROW_W    = $clog2(NUM_ROWS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                row_req,
    output logic [ROW_W-1:0]    row_addr,
    input  logic                row_vld,
    input  logic [DIST_W-1:0]   row_dist,
    input  logic [COORD_W-1:0]  row_x,
    input  logic [COORD_W-1:0]  row_y,
    input  logic [WGT_W-1:0]    row_w,
`ifdef BMU_SCAN_THRESH_EN
    input  logic [DIST_W-1:0]   thresh,
    output logic                no_match,
`endif
    output logic [DIST_W-1:0]   bmu_dist,
    output logic [COORD_W-1:0]  bmu_x,
    output logic [COORD_W-1:0]  bmu_y,
    output logic [ROW_W-1:0]    bmu_row,
    output logic [WGT_W-1:0]    bmu_w
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

    scan_state_t      r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_row_req;
    logic [ROW_W-1:0] r_row_addr;

    logic w_clr;
    logic w_accept;
    logic w_last;

    assign w_clr    = (r_state == ST_IDLE) && start;
    assign w_accept = (r_state == ST_SCAN) && row_vld;
    assign w_last   = (r_row_addr == LAST_ROW);

    assign busy     = r_busy;
    assign done     = r_done;
    assign row_req  = r_row_req;
    assign row_addr = r_row_addr;

    // Scan FSM with registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_row_req  <= 1'b0;
            r_row_addr <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_SCAN;
                        r_busy     <= 1'b1;
                        r_row_req  <= 1'b1;
                        r_row_addr <= '0;
                    end
                end
                ST_SCAN: begin
                    if (row_vld) begin
                        if (w_last) begin
                            r_state   <= ST_DONE;
                            r_busy    <= 1'b0;
                            r_row_req <= 1'b0;
                            r_done    <= 1'b1;
                        end else begin
                            r_row_addr <= r_row_addr + ROW_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    bmu_best_reg #(
        .ROW_W (ROW_W)
    ) u_best (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .i_vld  (w_accept),
        .i_dist (row_dist),
        .i_x    (row_x),
        .i_y    (row_y),
        .i_row  (r_row_addr),
        .i_w    (row_w),
        .o_dist (bmu_dist),
        .o_x    (bmu_x),
        .o_y    (bmu_y),
        .o_row  (bmu_row),
        .o_w    (bmu_w)
    );

`ifdef BMU_SCAN_THRESH_EN
    logic [DIST_W-1:0] r_thresh;
    logic              r_no_match;
    logic [DIST_W-1:0] w_final_dist;

    // Minimum including the last row, so the flag is valid alongside done
    assign w_final_dist = (row_dist < bmu_dist) ? row_dist : bmu_dist;
    assign no_match     = r_no_match;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_thresh   <= '0;
            r_no_match <= 1'b0;
        end else if (w_clr) begin
            r_thresh   <= thresh;
            r_no_match <= 1'b0;
        end else if (w_accept && w_last) begin
            r_no_match <= (w_final_dist > r_thresh);
        end
    end
`endif

endmodule
